// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection controller: phase FSM, seconds divider, BCD countdown and
// pedestrian request latch. Lamp vectors are {R,Y,G}, registered alongside the state.
module traffic_phase_sequencer #(
   parameter int unsigned TICK_DIV   = 50000000,
   parameter int unsigned GREEN_SEC  = 20,
   parameter int unsigned YELLOW_SEC = 3,
   parameter int unsigned ALLRED_SEC = 2,
   parameter int unsigned PED_SEC    = 5
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       Enable,
   input  logic       PedReq,
   output logic [2:0] MainLight,
   output logic [2:0] SideLight,
   output logic [3:0] Tens,
   output logic [3:0] Ones,
   output logic       PedWait,
   output logic       SecTick
);

   localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

   localparam logic [7:0] GreenBcd  = {4'(GREEN_SEC / 10), 4'(GREEN_SEC % 10)};
   localparam logic [7:0] YellowBcd = {4'(YELLOW_SEC / 10), 4'(YELLOW_SEC % 10)};
   localparam logic [7:0] AllRedBcd = {4'(ALLRED_SEC / 10), 4'(ALLRED_SEC % 10)};
   localparam logic [7:0] PedBcd    = {4'(PED_SEC / 10), 4'(PED_SEC % 10)};
   localparam logic [6:0] PedBin    = 7'(PED_SEC);

   localparam logic [2:0] LampR = 3'b100;
   localparam logic [2:0] LampY = 3'b010;
   localparam logic [2:0] LampG = 3'b001;

   typedef enum logic [2:0] {
      StMg  = 3'd0,
      StMy  = 3'd1,
      StAr1 = 3'd2,
      StSg  = 3'd3,
      StSy  = 3'd4,
      StAr2 = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic [3:0]      tens_q, tens_d;
   logic [3:0]      ones_q, ones_d;
   logic            ped_q, ped_d;
   logic [2:0]      main_q, main_d;
   logic [2:0]      side_q, side_d;

   logic            tick;
   logic            cnt_one;
   logic [6:0]      cnt_bin;

   function automatic state_e next_phase(input state_e s);
      case (s)
         StMg:    next_phase = StMy;
         StMy:    next_phase = StAr1;
         StAr1:   next_phase = StSg;
         StSg:    next_phase = StSy;
         StSy:    next_phase = StAr2;
         default: next_phase = StMg;
      endcase
   endfunction

   function automatic logic [7:0] phase_bcd(input state_e s);
      case (s)
         StMy, StSy:   phase_bcd = YellowBcd;
         StAr1, StAr2: phase_bcd = AllRedBcd;
         default:      phase_bcd = GreenBcd;
      endcase
   endfunction

   // Returns {Main, Side}; illegal encodings map to the MG pattern.
   function automatic logic [5:0] phase_lamps(input state_e s);
      case (s)
         StMy:         phase_lamps = {LampY, LampR};
         StAr1, StAr2: phase_lamps = {LampR, LampR};
         StSg:         phase_lamps = {LampR, LampG};
         StSy:         phase_lamps = {LampR, LampY};
         default:      phase_lamps = {LampG, LampR};
      endcase
   endfunction

   assign tick    = Enable && (div_q == DivMax);
   assign cnt_one = (tens_q == 4'd0) && (ones_q == 4'd1);
   assign cnt_bin = 7'(tens_q) * 7'd10 + 7'(ones_q);

   always_comb begin
      div_d   = div_q;
      state_d = state_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      ped_d   = ped_q;

      if (Enable) begin
         div_d = tick ? '0 : div_q + 1'b1;
      end

      if (PedReq && (state_q != StSg)) begin
         ped_d = 1'b1;
      end

      case (state_q)
         StMg, StMy, StAr1, StSg, StSy, StAr2: begin
            if (tick) begin
               if (cnt_one) begin
                  state_d          = next_phase(state_q);
                  {tens_d, ones_d} = phase_bcd(state_d);
               end else if ((state_q == StMg) && ped_q && (cnt_bin > PedBin)) begin
                  // Registered latch only: a PedReq in this same cycle waits a tick.
                  {tens_d, ones_d} = PedBcd;
               end else if (ones_q == 4'd0) begin
                  tens_d = tens_q - 4'd1;
                  ones_d = 4'd9;
               end else begin
                  ones_d = ones_q - 4'd1;
               end
            end
         end
         default: begin
            state_d          = StMg;
            {tens_d, ones_d} = GreenBcd;
         end
      endcase

      if ((state_d == StSg) && (state_q != StSg)) begin
         ped_d = 1'b0;
      end

      {main_d, side_d} = phase_lamps(state_d);
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= StMg;
         div_q   <= '0;
         tens_q  <= GreenBcd[7:4];
         ones_q  <= GreenBcd[3:0];
         ped_q   <= 1'b0;
         main_q  <= LampG;
         side_q  <= LampR;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         ped_q   <= ped_d;
         main_q  <= main_d;
         side_q  <= side_d;
      end
   end

   assign MainLight = main_q;
   assign SideLight = side_q;
   assign Tens      = tens_q;
   assign Ones      = ones_q;
   assign PedWait   = ped_q;
   assign SecTick   = tick;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench: three sequencer instances with different phase timings share one clock.
module tb_traffic_phase_sequencer;

   logic       clk;
   logic       rst_n    [3];
   logic       en       [3];
   logic       ped      [3];
   logic [2:0] main_l   [3];
   logic [2:0] side_l   [3];
   logic [3:0] tens     [3];
   logic [3:0] ones     [3];
   logic       ped_wait [3];
   logic       sec_tick [3];

   int pass_cnt  = 0;
   int total_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Full-cycle timing
   traffic_phase_sequencer #(
      .TICK_DIV(4), .GREEN_SEC(3), .YELLOW_SEC(2), .ALLRED_SEC(1), .PED_SEC(1)
   ) u_dut_a (
      .Clock(clk), .Resetn(rst_n[0]), .Enable(en[0]), .PedReq(ped[0]),
      .MainLight(main_l[0]), .SideLight(side_l[0]), .Tens(tens[0]), .Ones(ones[0]),
      .PedWait(ped_wait[0]), .SecTick(sec_tick[0])
   );

   // Reset, BCD borrow and pause
   traffic_phase_sequencer #(
      .TICK_DIV(4), .GREEN_SEC(12), .YELLOW_SEC(3), .ALLRED_SEC(2), .PED_SEC(5)
   ) u_dut_b (
      .Clock(clk), .Resetn(rst_n[1]), .Enable(en[1]), .PedReq(ped[1]),
      .MainLight(main_l[1]), .SideLight(side_l[1]), .Tens(tens[1]), .Ones(ones[1]),
      .PedWait(ped_wait[1]), .SecTick(sec_tick[1])
   );

   // Pedestrian shortening and mid-phase reset
   traffic_phase_sequencer #(
      .TICK_DIV(4), .GREEN_SEC(20), .YELLOW_SEC(3), .ALLRED_SEC(2), .PED_SEC(5)
   ) u_dut_c (
      .Clock(clk), .Resetn(rst_n[2]), .Enable(en[2]), .PedReq(ped[2]),
      .MainLight(main_l[2]), .SideLight(side_l[2]), .Tens(tens[2]), .Ones(ones[2]),
      .PedWait(ped_wait[2]), .SecTick(sec_tick[2])
   );

   typedef struct {
      logic       en;
      logic [2:0] main;
      logic [2:0] side;
      logic [3:0] tens;
      logic [3:0] ones;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance past the next SecTick of instance d; a missing tick counts as a failure.
   task automatic wait_tick(input int d);
      int n = 0;
      while (sec_tick[d] !== 1'b1 && n < 16) begin
         step(1);
         n++;
      end
      if (sec_tick[d] !== 1'b1) begin
         total_cnt++;
         $display("FAIL tick_timeout dut%0d: got no SecTick, expected one within 16 cycles", d);
      end
      step(1);
   endtask

   task automatic chk_disp(input string nm, input int d, input logic [2:0] m, input logic [2:0] s,
                           input logic [3:0] t, input logic [3:0] o);
      chk({nm, "_main"}, 32'(main_l[d]), 32'(m));
      chk({nm, "_side"}, 32'(side_l[d]), 32'(s));
      chk({nm, "_tens"}, 32'(tens[d]), 32'(t));
      chk({nm, "_ones"}, 32'(ones[d]), 32'(o));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 3'b001, 3'b100, 4'd0, 4'd3};
      tbl[1]  = '{1'b1, 3'b001, 3'b100, 4'd0, 4'd2};
      tbl[2]  = '{1'b1, 3'b001, 3'b100, 4'd0, 4'd1};
      tbl[3]  = '{1'b1, 3'b010, 3'b100, 4'd0, 4'd2};
      tbl[4]  = '{1'b1, 3'b010, 3'b100, 4'd0, 4'd1};
      tbl[5]  = '{1'b1, 3'b100, 3'b100, 4'd0, 4'd1};
      tbl[6]  = '{1'b1, 3'b100, 3'b001, 4'd0, 4'd3};
      tbl[7]  = '{1'b1, 3'b100, 3'b001, 4'd0, 4'd2};
      tbl[8]  = '{1'b1, 3'b100, 3'b001, 4'd0, 4'd1};
      tbl[9]  = '{1'b1, 3'b100, 3'b010, 4'd0, 4'd2};
      tbl[10] = '{1'b1, 3'b100, 3'b010, 4'd0, 4'd1};
      tbl[11] = '{1'b1, 3'b100, 3'b100, 4'd0, 4'd1};
      tbl[12] = '{1'b1, 3'b001, 3'b100, 4'd0, 4'd3};

      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0;
         en[i]    = 1'b1;
         ped[i]   = 1'b0;
      end
      step(3);

      // Reset held with Enable=1
      chk_disp("rst_b", 1, 3'b001, 3'b100, 4'd1, 4'd2);
      chk("rst_b_pedwait", 32'(ped_wait[1]), 32'd0);
      chk("rst_b_sectick", 32'(sec_tick[1]), 32'd0);

      // Full phase cycle, one table row per tick
      @(negedge clk);
      rst_n[0] = 1'b1;
      for (int i = 0; i < 13; i++) begin
         en[0] = tbl[i].en;
         if (i > 0) begin
            step(3);
            chk($sformatf("cyc%0d_pretick", i), 32'(sec_tick[0]), 32'd1);
            chk($sformatf("cyc%0d_hold_main", i), 32'(main_l[0]), 32'(tbl[i-1].main));
            chk($sformatf("cyc%0d_hold_side", i), 32'(side_l[0]), 32'(tbl[i-1].side));
            step(1);
            chk($sformatf("cyc%0d_sectick", i), 32'(sec_tick[0]), 32'd0);
         end
         chk_disp($sformatf("cyc%0d", i), 0, tbl[i].main, tbl[i].side, tbl[i].tens, tbl[i].ones);
      end

      // First tick after release, then BCD borrow 10 -> 09
      @(negedge clk);
      rst_n[1] = 1'b1;
      step(3);
      chk("b_first_tick", 32'(sec_tick[1]), 32'd1);
      chk_disp("b_pre", 1, 3'b001, 3'b100, 4'd1, 4'd2);
      step(1);
      chk_disp("b_11", 1, 3'b001, 3'b100, 4'd1, 4'd1);
      wait_tick(1);
      chk_disp("b_10", 1, 3'b001, 3'b100, 4'd1, 4'd0);
      wait_tick(1);
      chk_disp("b_09", 1, 3'b001, 3'b100, 4'd0, 4'd9);

      // Pause with the divider at 2; it resumes from the held count
      step(2);
      en[1] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk("pause_sectick", 32'(sec_tick[1]), 32'd0);
         chk("pause_disp", 32'({tens[1], ones[1]}), 32'h09);
         chk("pause_main", 32'(main_l[1]), 32'b001);
      end
      en[1] = 1'b1;
      step(1);
      chk("resume_tick", 32'(sec_tick[1]), 32'd1);
      chk("resume_disp_pre", 32'({tens[1], ones[1]}), 32'h09);
      step(1);
      chk("resume_disp", 32'({tens[1], ones[1]}), 32'h08);

      // Pedestrian request at 18 shortens MG to 05
      @(negedge clk);
      rst_n[2] = 1'b1;
      wait_tick(2);
      wait_tick(2);
      chk_disp("ped_18", 2, 3'b001, 3'b100, 4'd1, 4'd8);
      chk("ped_idle", 32'(ped_wait[2]), 32'd0);
      ped[2] = 1'b1;
      step(1);
      ped[2] = 1'b0;
      chk("ped_latched", 32'(ped_wait[2]), 32'd1);
      chk("ped_no_early", 32'({tens[2], ones[2]}), 32'h18);
      wait_tick(2);
      chk_disp("ped_05", 2, 3'b001, 3'b100, 4'd0, 4'd5);
      repeat (4) wait_tick(2);
      chk_disp("ped_01", 2, 3'b001, 3'b100, 4'd0, 4'd1);
      wait_tick(2);
      chk_disp("ped_my", 2, 3'b010, 3'b100, 4'd0, 4'd3);
      chk("ped_wait_my", 32'(ped_wait[2]), 32'd1);
      repeat (3) wait_tick(2);
      chk_disp("ped_ar1", 2, 3'b100, 3'b100, 4'd0, 4'd2);
      chk("ped_wait_ar1", 32'(ped_wait[2]), 32'd1);
      repeat (2) wait_tick(2);
      chk_disp("ped_sg", 2, 3'b100, 3'b001, 4'd2, 4'd0);
      chk("ped_clear_sg", 32'(ped_wait[2]), 32'd0);
      ped[2] = 1'b1;
      step(2);
      ped[2] = 1'b0;
      step(1);
      chk("ped_ignored_sg", 32'(ped_wait[2]), 32'd0);

      // Asynchronous reset in the middle of SY
      repeat (20) wait_tick(2);
      chk_disp("sy", 2, 3'b100, 3'b010, 4'd0, 4'd3);
      step(1);
      #3;
      rst_n[2] = 1'b0;
      #1;
      chk_disp("midrst", 2, 3'b001, 3'b100, 4'd2, 4'd0);
      chk("midrst_pedwait", 32'(ped_wait[2]), 32'd0);
      chk("midrst_sectick", 32'(sec_tick[2]), 32'd0);
      @(negedge clk);
      rst_n[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("post_rst_main", 32'(main_l[2]), 32'b001);
         chk("post_rst_side", 32'(side_l[2]), 32'b100);
      end
      chk("post_rst_tick", 32'(sec_tick[2]), 32'd1);
      step(1);
      chk("post_rst_19", 32'({tens[2], ones[2]}), 32'h19);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
